// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and load/store.
// Load/store normally wins. A starvation counter forces a fetch grant after
// STARVE_MAX consecutive load/store grants taken while a fetch was waiting.
// At most one memory transaction is outstanding.
//
// Handshake semantics:
//   - Requesters hold i_*_req and their fields stable until o_if_rvalid or
//     o_ls_done. A fetch may also be cancelled with i_if_flush.
//   - The memory request o_mem_req stays high with stable fields until the
//     cycle i_mem_gnt is seen. It is never withdrawn.
//   - Each granted access ends with one i_mem_rvalid, including writes.
//     i_mem_rvalid seen in any state other than WAIT is ignored.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_if_flush,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  output logic        o_if_stall,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_be,
  output logic        o_ls_done,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_stall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic [1:0]  o_dbg_state,
  output logic [2:0]  o_dbg_starve_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t     state;
  logic [2:0] starve_cnt;
  logic       owner_ls;     // 1: current transaction belongs to load/store
  logic       drop;         // owned fetch was flushed; swallow its response
  logic       if_rvalid_q;
  logic       if_pending;
  logic       grant_if;
  logic       grant_ls;

  // Arbitration: a flushed fetch is not a candidate; fetch wins only when starved.
  always_comb begin
    if_pending = i_if_req & ~i_if_flush;
    grant_if   = if_pending & (~i_ls_req | (starve_cnt == STARVE_LIM));
    grant_ls   = i_ls_req & ~grant_if;
  end

  // A flush in the response cycle itself still cancels the pulse.
  assign o_if_rvalid      = if_rvalid_q & ~i_if_flush;
  assign o_if_stall       = i_if_req & ~o_if_rvalid & ~i_if_flush;
  assign o_ls_stall       = i_ls_req & ~o_ls_done;
  assign o_dbg_state      = state;
  assign o_dbg_starve_cnt = starve_cnt;

  // Transaction FSM with registered memory port and response outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      starve_cnt  <= 3'd0;
      owner_ls    <= 1'b0;
      drop        <= 1'b0;
      if_rvalid_q <= 1'b0;
      o_ls_done   <= 1'b0;
      o_if_rdata  <= 32'd0;
      o_ls_rdata  <= 32'd0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= 32'd0;
      o_mem_wdata <= 32'd0;
      o_mem_be    <= 4'd0;
    end else begin
      if_rvalid_q <= 1'b0;
      o_ls_done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_ls) begin
            state       <= ST_REQ;
            owner_ls    <= 1'b1;
            o_mem_req   <= 1'b1;
            o_mem_we    <= i_ls_we;
            o_mem_addr  <= i_ls_addr;
            o_mem_wdata <= i_ls_wdata;
            o_mem_be    <= i_ls_be;
            if (if_pending && (starve_cnt != STARVE_LIM))
              starve_cnt <= starve_cnt + 3'd1;
          end else if (grant_if) begin
            state       <= ST_REQ;
            owner_ls    <= 1'b0;
            o_mem_req   <= 1'b1;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= i_if_addr;
            o_mem_wdata <= 32'd0;
            o_mem_be    <= 4'hf;
            starve_cnt  <= 3'd0;
          end
        end
        ST_REQ: begin
          if (!owner_ls && i_if_flush) drop <= 1'b1;
          if (i_mem_gnt) begin
            state     <= ST_WAIT;
            o_mem_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!owner_ls && i_if_flush) drop <= 1'b1;
          if (i_mem_rvalid) begin
            state <= ST_RESP;
            if (owner_ls) begin
              o_ls_done <= 1'b1;
              if (!o_mem_we) o_ls_rdata <= i_mem_rdata;
            end else if (!drop && !i_if_flush) begin
              if_rvalid_q <= 1'b1;
              o_if_rdata  <= i_mem_rdata;
            end
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          drop  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch latency, load-over-fetch
// priority, starvation override, flush drop, held request and mid-transaction reset.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        ls_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_starve_cnt;

  int n_checks;
  int n_fail;

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_if_req         (if_req),
    .i_if_addr        (if_addr),
    .i_if_flush       (if_flush),
    .o_if_rvalid      (if_rvalid),
    .o_if_rdata       (if_rdata),
    .o_if_stall       (if_stall),
    .i_ls_req         (ls_req),
    .i_ls_we          (ls_we),
    .i_ls_addr        (ls_addr),
    .i_ls_wdata       (ls_wdata),
    .i_ls_be          (ls_be),
    .o_ls_done        (ls_done),
    .o_ls_rdata       (ls_rdata),
    .o_ls_stall       (ls_stall),
    .o_mem_req        (mem_req),
    .o_mem_we         (mem_we),
    .o_mem_addr       (mem_addr),
    .o_mem_wdata      (mem_wdata),
    .o_mem_be         (mem_be),
    .i_mem_gnt        (mem_gnt),
    .i_mem_rvalid     (mem_rvalid),
    .i_mem_rdata      (mem_rdata),
    .o_dbg_state      (dbg_state),
    .o_dbg_starve_cnt (dbg_starve_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the directed sequence is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog timeout n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    if_req     = 1'b0;
    if_addr    = 32'd0;
    if_flush   = 1'b0;
    ls_req     = 1'b0;
    ls_we      = 1'b0;
    ls_addr    = 32'd0;
    ls_wdata   = 32'd0;
    ls_be      = 4'd0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;

    // ---- Reset state
    step();
    step();
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_ls_done", 32'(ls_done), 32'd0);
    chk("rst_starve", 32'(dbg_starve_cnt), 32'd0);
    reset = 1'b0;
    step();

    // ---- Fetch only, minimum latency
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    chk("f_stall_c0", 32'(if_stall), 32'd1);
    step();                                       // cycle 1
    chk("f_state_c1", 32'(dbg_state), 32'd1);
    chk("f_mem_req_c1", 32'(mem_req), 32'd1);
    chk("f_mem_addr_c1", mem_addr, 32'h100);
    chk("f_mem_we_c1", 32'(mem_we), 32'd0);
    chk("f_stall_c1", 32'(if_stall), 32'd1);
    mem_gnt = 1'b1;
    step();                                       // cycle 2
    chk("f_state_c2", 32'(dbg_state), 32'd2);
    chk("f_mem_req_c2", 32'(mem_req), 32'd0);
    chk("f_stall_c2", 32'(if_stall), 32'd1);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    step();                                       // cycle 3
    chk("f_rvalid_c3", 32'(if_rvalid), 32'd1);
    chk("f_rdata_c3", if_rdata, 32'h0000_0013);
    chk("f_stall_c3", 32'(if_stall), 32'd0);
    mem_rvalid = 1'b0; if_req = 1'b0;
    step();                                       // cycle 4
    chk("f_rvalid_c4", 32'(if_rvalid), 32'd0);
    chk("f_state_c4", 32'(dbg_state), 32'd0);
    chk("f_rdata_hold", if_rdata, 32'h0000_0013);

    // ---- Fetch and load both pending: load first
    if_req = 1'b1; if_addr = 32'h200;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300; ls_be = 4'hf;
    step();                                       // cycle 1
    chk("p_mem_addr_ld", mem_addr, 32'h300);
    chk("p_mem_we_ld", 32'(mem_we), 32'd0);
    mem_gnt = 1'b1;
    step();                                       // cycle 2
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAABB_CCDD;
    step();                                       // cycle 3
    chk("p_ls_done", 32'(ls_done), 32'd1);
    chk("p_ls_rdata", ls_rdata, 32'hAABB_CCDD);
    chk("p_if_rvalid_early", 32'(if_rvalid), 32'd0);
    chk("p_ls_stall", 32'(ls_stall), 32'd0);
    chk("p_starve_1", 32'(dbg_starve_cnt), 32'd1);
    mem_rvalid = 1'b0; ls_req = 1'b0;
    step();                                       // cycle 4: IDLE, fetch arbitrated
    chk("p_ls_done_off", 32'(ls_done), 32'd0);
    step();                                       // cycle 5
    chk("p_mem_addr_f", mem_addr, 32'h200);
    chk("p_starve_clr", 32'(dbg_starve_cnt), 32'd0);
    mem_gnt = 1'b1;
    step();                                       // cycle 6
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    step();                                       // cycle 7
    chk("p_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("p_if_rdata", if_rdata, 32'h1111_2222);
    mem_rvalid = 1'b0; if_req = 1'b0;
    step();                                       // cycle 8: IDLE

    // ---- Starvation: 4 store grants, then fetch
    if_req = 1'b1; if_addr = 32'h400;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h500; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'hf;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5566_7788;
    for (int i = 0; i < 4; i++) begin
      step();                                     // REQ
      chk($sformatf("s_addr_%0d", i), mem_addr, 32'h500);
      chk($sformatf("s_we_%0d", i), 32'(mem_we), 32'd1);
      step();                                     // WAIT
      step();                                     // RESP
      chk($sformatf("s_done_%0d", i), 32'(ls_done), 32'd1);
      chk($sformatf("s_starve_%0d", i), 32'(dbg_starve_cnt), 32'(i + 1));
      step();                                     // IDLE
    end
    step();                                       // REQ for the 5th grant
    chk("s_fetch_addr", mem_addr, 32'h400);
    chk("s_fetch_we", 32'(mem_we), 32'd0);
    chk("s_starve_zero", 32'(dbg_starve_cnt), 32'd0);
    step();                                       // WAIT
    step();                                       // RESP
    chk("s_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("s_if_rdata", if_rdata, 32'h5566_7788);
    chk("s_ls_rdata_kept", ls_rdata, 32'hAABB_CCDD);
    if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    step();                                       // IDLE

    // ---- Flush while fetch is in WAIT
    if_req = 1'b1; if_addr = 32'h600;
    step();                                       // cycle 1: REQ
    mem_gnt = 1'b1;
    step();                                       // cycle 2: WAIT
    chk("fl_state_wait", 32'(dbg_state), 32'd2);
    mem_gnt = 1'b0; if_flush = 1'b1; if_req = 1'b0;
    step();                                       // cycle 3: still WAIT
    chk("fl_still_wait", 32'(dbg_state), 32'd2);
    if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0099;
    step();                                       // cycle 4: RESP
    chk("fl_state_resp", 32'(dbg_state), 32'd3);
    chk("fl_no_rvalid", 32'(if_rvalid), 32'd0);
    chk("fl_rdata_kept", if_rdata, 32'h5566_7788);
    mem_rvalid = 1'b0;
    step();                                       // cycle 5: IDLE
    chk("fl_idle", 32'(dbg_state), 32'd0);
    chk("fl_no_rvalid_2", 32'(if_rvalid), 32'd0);

    // ---- Grant withheld 5 cycles on a partial store
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h700; ls_wdata = 32'h1234_5678; ls_be = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("h_req_%0d", i), 32'(mem_req), 32'd1);
      chk($sformatf("h_be_%0d", i), 32'(mem_be), 32'h3);
      chk($sformatf("h_addr_%0d", i), mem_addr, 32'h700);
      chk($sformatf("h_wdata_%0d", i), mem_wdata, 32'h1234_5678);
    end
    mem_gnt = 1'b1;
    step();                                       // WAIT
    chk("h_req_drop", 32'(mem_req), 32'd0);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
    step();                                       // RESP
    chk("h_done", 32'(ls_done), 32'd1);
    chk("h_ls_rdata_kept", ls_rdata, 32'hAABB_CCDD);
    mem_rvalid = 1'b0; ls_req = 1'b0;
    step();                                       // IDLE

    // ---- Reset in WAIT, then a fresh fetch
    if_req = 1'b1; if_addr = 32'h800;
    step();                                       // REQ
    mem_gnt = 1'b1;
    step();                                       // WAIT
    mem_gnt = 1'b0; reset = 1'b1; if_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;  // reset outranks this
    step();
    chk("r_state", 32'(dbg_state), 32'd0);
    chk("r_mem_req", 32'(mem_req), 32'd0);
    chk("r_mem_addr", mem_addr, 32'd0);
    chk("r_mem_be", 32'(mem_be), 32'd0);
    chk("r_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("r_if_rdata", if_rdata, 32'd0);
    chk("r_ls_rdata", ls_rdata, 32'd0);
    chk("r_starve", 32'(dbg_starve_cnt), 32'd0);
    reset = 1'b0; mem_rvalid = 1'b0;
    if_req = 1'b1; if_addr = 32'h900;
    step();                                       // REQ
    chk("r2_mem_addr", mem_addr, 32'h900);
    mem_gnt = 1'b1;
    step();                                       // WAIT
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();                                       // RESP
    chk("r2_rvalid", 32'(if_rvalid), 32'd1);
    chk("r2_rdata", if_rdata, 32'hCAFE_F00D);
    mem_rvalid = 1'b0; if_req = 1'b0;
    step();
    chk("r2_idle", 32'(dbg_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive load/store grants allowed while fetch waits.
REQ-002 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_if_req  in  1  fetch request; held with i_if_addr until o_if_rvalid or flush.
REQ-005 i_if_addr  in  32  fetch word address.
REQ-006 i_if_flush  in  1  cancel the current fetch (taken branch).
REQ-007 o_if_rvalid  out  1  one-cycle pulse with o_if_rdata valid.
REQ-008 o_if_rdata  out  32  fetched instruction.
REQ-009 o_if_stall  out  1  = i_if_req & ~o_if_rvalid & ~i_if_flush.
REQ-010 i_ls_req  in  1  load/store request; held with all i_ls_* inputs until o_ls_done.
REQ-011 i_ls_we, i_ls_addr, i_ls_wdata, i_ls_be  in  1/32/32/4  write enable, address, store data, byte enables.
REQ-012 o_ls_done  out  1  one-cycle completion pulse; o_ls_rdata valid when i_ls_we was 0.
REQ-013 o_ls_rdata  out  32  load data.
REQ-014 o_ls_stall  out  1  = i_ls_req & ~o_ls_done.
REQ-015 o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be  out  1/1/32/32/4  single memory port request, all registered.
REQ-016 i_mem_gnt  in  1  memory accepted o_mem_req this cycle.
REQ-017 i_mem_rvalid, i_mem_rdata  in  1/32  completion for the outstanding access (writes included), data for reads.

Function
REQ-018 FSM states IDLE, REQ, WAIT, RESP; at most one memory transaction outstanding.
REQ-019 IDLE: if any request is pending, arbitrate, latch winner's fields into o_mem_* and owner flag, go to REQ; else stay.
REQ-020 Arbitration: load/store wins over fetch, except fetch wins when both pending and starve_cnt == STARVE_MAX.
REQ-021 starve_cnt (3 bits): +1 on load/store grant with i_if_req pending; cleared on fetch grant; saturates at STARVE_MAX.
REQ-022 Fetch request with i_if_flush high in the same cycle is not arbitrated.
REQ-023 REQ: o_mem_req=1, fields stable; on i_mem_gnt go to WAIT, else hold (no withdrawal).
REQ-024 WAIT: o_mem_req=0; on i_mem_rvalid capture i_mem_rdata, go to RESP.
REQ-025 RESP: pulse o_if_rvalid or o_ls_done per owner for exactly one cycle, then IDLE; no arbitration in RESP.
REQ-026 Minimum latency with gnt in the REQ cycle and rvalid the next cycle: request seen cycle 0, response pulse cycle 3.
REQ-027 i_if_flush while a fetch is owned (REQ/WAIT/RESP): set drop flag; transaction completes on bus; o_if_rvalid suppressed; drop cleared on return to IDLE.
REQ-028 i_mem_rvalid outside WAIT is ignored.
REQ-029 o_if_rdata/o_ls_rdata hold their last captured value between pulses.

Reset
REQ-030 i_reset high: state=IDLE, starve_cnt=0, drop=0, all o_mem_* = 0, o_if_rvalid=o_ls_done=0, rdata outputs=0.
REQ-031 Reset mid-transaction abandons it; the memory shares i_reset, so no stale i_mem_rvalid is expected.
REQ-032 Reset has priority over every other input in the same cycle.

Verification
REQ-033 Fetch only, addr 0x100, gnt immediate, rvalid 1 cycle later with 0x00000013 -> o_if_rvalid at cycle 3, o_if_rdata=0x00000013, o_if_stall high cycles 0-2.
REQ-034 Fetch and load both pending from cycle 0 -> load served first (o_mem_we=0), o_ls_done precedes any fetch response.
REQ-035 Fetch held, store pending continuously -> after 4 store grants the 5th grant goes to fetch; starve_cnt returns to 0.
REQ-036 Fetch granted, i_if_flush pulsed in WAIT -> bus access completes, o_if_rvalid stays 0, FSM returns to IDLE.
REQ-037 i_mem_gnt withheld 5 cycles in REQ -> o_mem_req and fields stable all 5 cycles; store byte enables 0b0011 appear unchanged on o_mem_be.
REQ-038 i_reset asserted in WAIT -> next cycle all outputs 0, state IDLE; a new fetch afterwards completes normally.
